mux2x1_rr: RTL
==============

// Module: mux2x1_rr
// PURPOSE
//   Merges two valid-qualified 8-bit lanes into one output stream; inverse of the 1:2 lane demux.
//   Each lane has its own DEPTH-entry FIFO; a round-robin arbiter pops one word per cycle into
//   a registered output. Used to recombine split lanes before the downstream consumer.
// PARAMETERS
//   DATA_W  8  width of data buses
//   DEPTH   4  entries per lane FIFO; power of two, >= 2
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       asynchronous, active-low reset
//   in0        in   DATA_W  lane 0 data
//   validIn0   in   1       lane 0 data valid; one word per cycle when high
//   in1        in   DATA_W  lane 1 data
//   validIn1   in   1       lane 1 data valid
//   out        out  DATA_W  merged data, registered
//   validOut   out  1       out holds a new word this cycle, registered
//   full0      out  1       lane 0 FIFO holds DEPTH words (combinational from count)
//   full1      out  1       lane 1 FIFO holds DEPTH words
//   overflow0  out  1       sticky: a lane 0 word was dropped
//   overflow1  out  1       sticky: a lane 1 word was dropped
// BEHAVIOUR
// - reset low (async): out=0, validOut=0, both FIFOs empty (ptrs/counts 0), overflow0/1=0,
//   last_grant=1 (lane 0 has priority first). Applies immediately, mid-transfer included; queued data lost.
// - Write: on each edge with validInX=1, inX is pushed into lane X FIFO, unless lane X is full
//   AND not popped at that same edge -> word dropped, overflowX set, stays 1 until reset.
//   Full lane that is popped at the same edge accepts the write (count unchanged).
// - Arbitration (combinational, on FIFO state before the edge):
//   both lanes non-empty -> grant lane != last_grant; one non-empty -> grant it; none -> no grant.
//   Every grant updates last_grant to the granted lane.
// - Output: on grant, out <= head of granted FIFO, validOut <= 1, that FIFO pops.
//   No grant: validOut <= 0, out holds its last value.
// - Latency: word sampled at edge N is at the earliest on out with validOut=1 after edge N+1
//   (2 edges); no same-cycle bypass from inX to out.
// - Throughput: exactly one output word per cycle while any FIFO is non-empty; with both lanes
//   streaming continuously, lanes alternate 0,1,0,1 and total input rate 2/cycle overflows.
// - Pointers: DEPTH-wide wrap via log2(DEPTH) bits; count 0..DEPTH (log2(DEPTH)+1 bits).
// - Ordering: per-lane order preserved; no cross-lane ordering guarantee other than round-robin.
// TESTING
//   1 Reset: drive reset=0 mid-stream with FIFOs partly full -> out=0, validOut=0, full*=0,
//     overflow*=0 immediately; after release, first lone word on in1 appears 2 edges later.
//   2 Single lane: in0=0x11,0x22,0x33 on 3 consecutive cycles, lane 1 idle -> out=0x11,0x22,0x33
//     on 3 consecutive cycles starting 2 edges after first, validOut then drops to 0, out holds 0x33.
//   3 Round-robin: in0=0xA0 and in1=0xB0 in the same cycle after reset -> out 0xA0 then 0xB0;
//     repeat with 0xA1/0xB1 next -> 0xA1 then 0xB1 (lane 0 granted first each tie after lane 1).
//   4 Full/overflow: both lanes valid every cycle for 2*DEPTH+2 cycles (in0=0x00.., in1=0x80..)
//     -> full0/full1 assert, overflow0 and overflow1 go 1 and stay 1; words out are a
//     per-lane in-order subset with no duplicates.
//   5 Write-at-full with pop: lane 0 at DEPTH, lane 1 empty, push in0=0x5A -> accepted,
//     overflow0 stays 0, 0x5A emerges after the DEPTH queued words.
//   6 Idle gaps: alternate valid/idle on both lanes with 0xC0.. pattern -> validOut only on
//     cycles with a queued word, no word lost or repeated.

Source files
------------

// File: rtl/mux2x1_rr.sv
// -----------------------------------------------------------------------------
// mux2x1_rr
//   Merges two valid-qualified lanes into a single registered output stream.
//   Each lane is buffered in its own DEPTH-entry FIFO. A round-robin arbiter
//   pops at most one word per cycle from the FIFOs into the output register.
//
// Parameters
//   DATA_W     width of the data buses
//   DEPTH      entries per lane FIFO (power of two, >= 2)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   in0        lane 0 data
//   validIn0   lane 0 data valid (one word per cycle while high)
//   in1        lane 1 data
//   validIn1   lane 1 data valid
//   out        merged data, registered; holds its value when no word is issued
//   validOut   out carries a new word this cycle, registered
//   full0      lane 0 FIFO holds DEPTH words
//   full1      lane 1 FIFO holds DEPTH words
//   overflow0  sticky flag: a lane 0 word was dropped
//   overflow1  sticky flag: a lane 1 word was dropped
// -----------------------------------------------------------------------------
module mux2x1_rr #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0,
    input  logic              validIn0,
    input  logic [DATA_W-1:0] in1,
    input  logic              validIn1,
    output logic [DATA_W-1:0] out,
    output logic              validOut,
    output logic              full0,
    output logic              full1,
    output logic              overflow0,
    output logic              overflow1
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Lane inputs gathered into arrays so both FIFOs come from one generate loop.
    logic [DATA_W-1:0] lane_data [2];
    logic [1:0]        lane_valid;

    assign lane_data[0] = in0;
    assign lane_data[1] = in1;
    assign lane_valid   = {validIn1, validIn0};

    logic [1:0]        non_empty;
    logic [1:0]        full;
    logic [1:0]        pop;
    logic [1:0]        overflow;
    logic [DATA_W-1:0] head [2];

    logic              grant_valid;
    logic              grant_lane;
    logic              last_grant_reg;

    logic [DATA_W-1:0] out_reg;
    logic              valid_out_reg;

    // -------------------------------------------------------------------------
    // Per-lane FIFO
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic [DATA_W-1:0] mem [DEPTH];
            logic [PTR_W-1:0]  wr_ptr_reg;
            logic [PTR_W-1:0]  rd_ptr_reg;
            logic [CNT_W-1:0]  count_reg;
            logic              overflow_reg;
            logic              push;

            assign full[gi]      = (count_reg == CNT_W'(DEPTH));
            assign non_empty[gi] = (count_reg != '0);
            assign pop[gi]       = grant_valid && (grant_lane == 1'(gi));
            // A full lane still accepts a write when it is being popped on the
            // same edge: the freed slot is reused and the count stays at DEPTH.
            assign push          = lane_valid[gi] && (!full[gi] || pop[gi]);
            assign head[gi]      = mem[rd_ptr_reg];
            assign overflow[gi]  = overflow_reg;

            // Storage carries no reset; queued words are discarded by clearing
            // the pointers and count.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr_reg] <= lane_data[gi];
                end
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    if (push) begin
                        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                    end
                    case ({push, pop[gi]})
                        2'b10:   count_reg <= count_reg + CNT_W'(1);
                        2'b01:   count_reg <= count_reg - CNT_W'(1);
                        default: count_reg <= count_reg;
                    endcase
                    if (lane_valid[gi] && !push) begin
                        overflow_reg <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbiter on the pre-edge FIFO state
    // -------------------------------------------------------------------------
    always_comb begin
        grant_valid = |non_empty;
        grant_lane  = 1'b0;
        if (&non_empty) begin
            // Contention: the lane that did not win last time goes next.
            grant_lane = ~last_grant_reg;
        end else if (non_empty[1]) begin
            grant_lane = 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Output register and grant history
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_reg        <= '0;
            valid_out_reg  <= 1'b0;
            last_grant_reg <= 1'b1;   // lane 0 wins the first tie
        end else if (grant_valid) begin
            out_reg        <= head[grant_lane];
            valid_out_reg  <= 1'b1;
            last_grant_reg <= grant_lane;
        end else begin
            valid_out_reg  <= 1'b0;
        end
    end

    assign out       = out_reg;
    assign validOut  = valid_out_reg;
    assign full0     = full[0];
    assign full1     = full[1];
    assign overflow0 = overflow[0];
    assign overflow1 = overflow[1];

endmodule
